uart_tx_arbiter: RTL

//  Round-robin scheduler that shares one UART transmitter among NUM_REQ byte sources.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, parity constants, clog2.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index,
   output logic               any
);

   // Scan from farthest to nearest candidate so the nearest one after ptr wins.
   always_comb begin
      int cand;
      cand  = 0;
      index = '0;
      any   = |req;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (req[cand]) index = IDX_W'(cand);
      end
      grant = any ? (NUM_REQ'(1) << index) : '0;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX among NUM_REQ byte sources.
// err_timeout is registered: it is visible in the cycle after the last
// WAIT_BUSY cycle (the first GAP cycle).
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 2,
   parameter int BUSY_TO    = 4,
   localparam int IDX_W     = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1,
   localparam int CNT_MAX   = (GAP_CYCLES > BUSY_TO) ? GAP_CYCLES : BUSY_TO,
   localparam int CNT_W     = (clog2(CNT_MAX + 1) > 0) ? clog2(CNT_MAX + 1) : 1
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_par_en,
   input  logic [NUM_REQ-1:0]            req_par_typ,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          tx_busy,
   output logic [DATA_WIDTH-1:0]         tx_p_data,
   output logic                          tx_data_valid,
   output logic                          tx_party_en,
   output logic                          tx_party_typ,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          active,
   output logic                          err_timeout
);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arb_grant),
      .index (arb_idx),
      .any   (arb_any)
   );

   // Frame FSM: grant, launch strobe, busy tracking, timeout and idle gap.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= ST_IDLE;
         ptr           <= IDX_W'(NUM_REQ - 1);
         cnt           <= '0;
         req_ready     <= '0;
         tx_p_data     <= '0;
         tx_data_valid <= 1'b0;
         tx_party_en   <= 1'b0;
         tx_party_typ  <= 1'b0;
         grant_id      <= '0;
         active        <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         // Strobes default low; only the IDLE grant raises them for LAUNCH.
         tx_data_valid <= 1'b0;
         req_ready     <= '0;
         err_timeout   <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Never launch into a busy transmitter.
               if (arb_any && !tx_busy) begin
                  tx_p_data     <= req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                  tx_party_en   <= req_par_en[arb_idx];
                  tx_party_typ  <= req_par_typ[arb_idx];
                  grant_id      <= arb_idx;
                  ptr           <= arb_idx;
                  req_ready     <= arb_grant;
                  tx_data_valid <= 1'b1;
                  active        <= 1'b1;
                  state         <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               cnt   <= '0;
               state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= ST_WAIT_DONE;
               end else if (cnt == CNT_W'(BUSY_TO - 1)) begin
                  // TX never acknowledged: drop the frame, no retry.
                  err_timeout <= 1'b1;
                  cnt         <= '0;
                  if (GAP_CYCLES == 0) begin
                     active <= 1'b0;
                     state  <= ST_IDLE;
                  end else begin
                     state  <= ST_GAP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  cnt <= '0;
                  if (GAP_CYCLES == 0) begin
                     active <= 1'b0;
                     state  <= ST_IDLE;
                  end else begin
                     state  <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                  active <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               active <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
